ddr3_app_arbiter: RTL and testbench
===================================

# ddr3_app_arbiter

Two-requester arbiter and sequencer in front of the DDR3 memory interface user (app) port, clocked by the controller's div-4 user clock. It grants whole transactions round-robin, issues the command, streams write beats from the granted requester, and routes read beats back to it. One transaction is outstanding at a time, which keeps read-data ownership unambiguous.

## Interface
- `ADDR_W`, 28: app address width (rank|bank|row|col).
- `DATA_W`, 128: app data width.
- `MASK_W`, `DATA_W/8`: write byte-mask width; bit = 1 masks the byte.
- `BURST_W`, 6: app_burst_number width; beats per transaction = burst + 1.

Ports (N = 0, 1; one identical group per requester):
- `clk` in 1: controller clk_out (mem/4).
- `rst` in 1: synchronous, active-high.
- `pN_req_valid` in 1: transaction request; held until accepted.
- `pN_req_ready` out 1: acceptance strobe.
- `pN_req_cmd` in 3: 3'd0 write, 3'd1 read; other values are rejected (see err).
- `pN_req_addr` in ADDR_W: start address.
- `pN_req_burst` in BURST_W: beats − 1.
- `pN_wdata_valid` in 1 / `pN_wdata_ready` out 1: write beat handshake.
- `pN_wdata` in DATA_W, `pN_wmask` in MASK_W: write beat.
- `pN_rvalid` out 1, `pN_rlast` out 1, `pN_rdata` out DATA_W: read beats; no backpressure.
- `init_calib_complete` in 1; `cmd_ready` in 1; `wr_data_rdy` in 1.
- `cmd_en` out 1, `cmd` out 3, `addr` out ADDR_W, `app_burst_number` out BURST_W.
- `wr_data_en` out 1, `wr_data_end` out 1, `wr_data` out DATA_W, `wr_data_mask` out MASK_W.
- `rd_data_valid` in 1, `rd_data` in DATA_W.
- `err` out 1: sticky; set by an illegal cmd or by an rd_data_valid outside RD_WAIT.

## Operation
- States: IDLE, CMD, WR_DATA, RD_WAIT.
- IDLE:
  - If `init_calib_complete` is high and any `pN_req_valid` is high, the arbiter grants one port.
  - The grant goes to the port that did not win last. If only one port requests, that port wins.
  - `pN_req_ready` is high combinationally for the granted port only.
  - On acceptance, cmd/addr/burst are latched, the beat counter is cleared, the last-winner pointer is updated, and the state moves to CMD.
  - An illegal cmd is accepted, sets `err`, and is dropped; the state stays IDLE.
- CMD, read:
  - `cmd_en` = `cmd_ready`.
  - On `cmd_en`, the state moves to RD_WAIT.
- CMD, write:
  - `cmd_en` = `wr_data_en` = `cmd_ready & wr_data_rdy & pN_wdata_valid`. The first beat is issued in the same cycle as the command.
  - Beat count 1; the state moves to WR_DATA, or to IDLE if burst == 0.
- WR_DATA:
  - `wr_data_en` = `pN_wdata_ready` = `wr_data_rdy & pN_wdata_valid`.
  - When the counter equals burst on a beat, the state returns to IDLE.
- Write-side outputs:
  - `wr_data_end` equals `wr_data_en` on every beat (BL8, one 128-bit beat per burst).
  - `wr_data`/`wr_data_mask` are driven combinationally from the granted port.
- RD_WAIT:
  - Each `rd_data_valid` produces `pN_rvalid` for the owner and increments the counter.
  - On the beat where counter == burst, `pN_rlast` = 1 and the state returns to IDLE.
  - `rd_data` is broadcast to both `pN_rdata`; only `rvalid` is steered.
- `cmd`, `addr`, `app_burst_number` are driven from the latched registers and are stable from CMD until the next acceptance.
- Arithmetic: the beat counter is BURST_W bits and is compared against burst, so no overflow is possible (maximum 64 beats).

## Timing
- Reset values:
  - All outputs are 0, including `err` and `wr_data_mask`.
  - State is IDLE, the last-winner pointer is 1 (port 0 wins the first tie), counter is 0.
- Latency from `pN_req_valid` to `cmd_en`:
  - Minimum 1 cycle: acceptance in IDLE, command on the next cycle.
  - Back-to-back transactions have 1 IDLE cycle between them.
- Read latency is set by the controller; the arbiter adds 0 cycles to `rd_data_valid` → `pN_rvalid`.
- Simultaneous requests alternate strictly. A request that is withdrawn before acceptance is legal and ignored.
- If `init_calib_complete` drops mid-transaction, the transaction completes; no new grants are made until it returns high.
- `rst` mid-transaction abandons the transaction immediately. It must be asserted together with the controller reset.

## Structure
- Package `ddr3_app_pkg` holds:
  - CMD_WR = 3'd0, CMD_RD = 3'd1.
  - The state encoding.
  - Default widths: ADDR_W 28, DATA_W 128, BURST_W 6.
- Sub-module `rr_arb2`: 2-way round-robin grant with a last-winner register and an update-on-accept input.

## Test plan
- Port 0 write, addr 0, burst 7, data 0x0123…3210 +1 per beat, with `wr_data_rdy` always high → exactly 8 `wr_data_en` beats, the first one in the same cycle as `cmd_en` with `cmd` = 0; then the state returns to IDLE.
- Port 1 read, addr 0, burst 7; a controller model returns 8 beats → `p1_rvalid` ×8, `p1_rlast` on beat 8, `p0_rvalid` never asserts.
- Both ports request every cycle for 6 transactions → grants go 0, 1, 0, 1, 0, 1.
- Toggle `wr_data_rdy` 1 cycle on, 1 cycle off during a burst-3 write → exactly 4 beats, and no `wr_data_en` while `wr_data_rdy` is 0.
- Inject `rd_data_valid` while in IDLE, and issue a request with cmd = 3'd5 → `err` = 1 and stays set; no `pN_rvalid` asserts.
- Assert `rst` in RD_WAIT after 3 beats → all outputs 0 on the next cycle; a new port 0 request is then granted first.

Source files
------------

// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the DDR3 app-port arbiter: command codes, the
// sequencer state encoding and the default port widths.
package ddr3_app_pkg;

    localparam int DEF_ADDR_W  = 28;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_BURST_W = 6;

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_WR_DATA = 2'd2,
        ST_RD_WAIT = 2'd3
    } state_e;

    function automatic logic cmd_legal(input logic [2:0] c);
        return (c == CMD_WR) || (c == CMD_RD);
    endfunction

endpackage

// File: rtl/ddr3_app_arbiter_rr_arb2.sv
// Two-way round-robin grant: a tie goes to the port that did not win last;
// the last-winner register only moves when the grant is actually accepted.
module rr_arb2
    import ddr3_app_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic last_r;

    // Grant decode from the live requests and the last winner.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_r ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Last-winner pointer; resets to 1 so port 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_r <= 1'b1;
        end else if (accept) begin
            last_r <= grant[1];
        end else begin
            last_r <= last_r;
        end
    end

endmodule

// File: rtl/ddr3_app_arbiter.sv
// Two-requester arbiter/sequencer for the DDR3 controller app port. One
// transaction is in flight at a time, so read beats always belong to owner_r.
module ddr3_app_arbiter
    import ddr3_app_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MASK_W  = DATA_W / 8,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               p0_req_valid,
    output logic               p0_req_ready,
    input  logic [2:0]         p0_req_cmd,
    input  logic [ADDR_W-1:0]  p0_req_addr,
    input  logic [BURST_W-1:0] p0_req_burst,
    input  logic               p0_wdata_valid,
    output logic               p0_wdata_ready,
    input  logic [DATA_W-1:0]  p0_wdata,
    input  logic [MASK_W-1:0]  p0_wmask,
    output logic               p0_rvalid,
    output logic               p0_rlast,
    output logic [DATA_W-1:0]  p0_rdata,
    input  logic               p1_req_valid,
    output logic               p1_req_ready,
    input  logic [2:0]         p1_req_cmd,
    input  logic [ADDR_W-1:0]  p1_req_addr,
    input  logic [BURST_W-1:0] p1_req_burst,
    input  logic               p1_wdata_valid,
    output logic               p1_wdata_ready,
    input  logic [DATA_W-1:0]  p1_wdata,
    input  logic [MASK_W-1:0]  p1_wmask,
    output logic               p1_rvalid,
    output logic               p1_rlast,
    output logic [DATA_W-1:0]  p1_rdata,
    input  logic               init_calib_complete,
    input  logic               cmd_ready,
    input  logic               wr_data_rdy,
    output logic               cmd_en,
    output logic [2:0]         cmd,
    output logic [ADDR_W-1:0]  addr,
    output logic [BURST_W-1:0] app_burst_number,
    output logic               wr_data_en,
    output logic               wr_data_end,
    output logic [DATA_W-1:0]  wr_data,
    output logic [MASK_W-1:0]  wr_data_mask,
    input  logic               rd_data_valid,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               err
);

    state_e             state_r;
    logic               owner_r;
    logic [2:0]         cmd_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [BURST_W-1:0] burst_r;
    logic [BURST_W-1:0] cnt_r;
    logic               err_r;

    logic [1:0]         arb_req_s;
    logic [1:0]         grant_s;
    logic               accept_s;
    logic [2:0]         sel_cmd_s;
    logic               owner_wvalid_s;
    logic               cmd_en_s;
    logic               wr_fire_s;
    logic               wr_path_s;
    logic               rd_beat_s;
    logic               rd_last_s;
    logic               err_set_s;

    // Grants are only offered while idle and calibrated.
    assign arb_req_s = (state_r == ST_IDLE && init_calib_complete)
                       ? {p1_req_valid, p0_req_valid} : 2'b00;
    assign accept_s  = |grant_s;
    assign sel_cmd_s = grant_s[1] ? p1_req_cmd : p0_req_cmd;
    assign owner_wvalid_s = owner_r ? p1_wdata_valid : p0_wdata_valid;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req    (arb_req_s),
        .accept (accept_s),
        .grant  (grant_s)
    );

    // Per-state handshake decode toward the controller and the owner port.
    always_comb begin
        cmd_en_s  = 1'b0;
        wr_fire_s = 1'b0;
        wr_path_s = 1'b0;
        rd_beat_s = 1'b0;
        rd_last_s = 1'b0;
        case (state_r)
            ST_CMD: begin
                if (cmd_r == CMD_RD) begin
                    cmd_en_s = cmd_ready;
                end else begin
                    wr_path_s = 1'b1;
                    wr_fire_s = cmd_ready & wr_data_rdy & owner_wvalid_s;
                    cmd_en_s  = wr_fire_s;
                end
            end
            ST_WR_DATA: begin
                wr_path_s = 1'b1;
                wr_fire_s = wr_data_rdy & owner_wvalid_s;
            end
            ST_RD_WAIT: begin
                rd_beat_s = rd_data_valid;
                rd_last_s = rd_data_valid & (cnt_r == burst_r);
            end
            default: begin
                cmd_en_s = 1'b0;
            end
        endcase
    end

    assign err_set_s = (accept_s & ~cmd_legal(sel_cmd_s))
                     | (rd_data_valid & (state_r != ST_RD_WAIT));

    // Sequencer state, latched command fields, beat counter and sticky error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            owner_r <= 1'b0;
            cmd_r   <= 3'd0;
            addr_r  <= '0;
            burst_r <= '0;
            cnt_r   <= '0;
            err_r   <= 1'b0;
        end else begin
            err_r <= err_r | err_set_s;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s && cmd_legal(sel_cmd_s)) begin
                        owner_r <= grant_s[1];
                        cmd_r   <= sel_cmd_s;
                        addr_r  <= grant_s[1] ? p1_req_addr  : p0_req_addr;
                        burst_r <= grant_s[1] ? p1_req_burst : p0_req_burst;
                        cnt_r   <= '0;
                        state_r <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (cmd_en_s) begin
                        if (cmd_r == CMD_RD) begin
                            state_r <= ST_RD_WAIT;
                        end else begin
                            cnt_r   <= BURST_W'(1);
                            state_r <= (burst_r == '0) ? ST_IDLE : ST_WR_DATA;
                        end
                    end
                end
                ST_WR_DATA: begin
                    if (wr_fire_s) begin
                        if (cnt_r == burst_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + BURST_W'(1);
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (rd_data_valid) begin
                        if (cnt_r == burst_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            cnt_r <= cnt_r + BURST_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign p0_req_ready     = grant_s[0];
    assign p1_req_ready     = grant_s[1];
    assign p0_wdata_ready   = wr_fire_s & ~owner_r;
    assign p1_wdata_ready   = wr_fire_s &  owner_r;
    assign p0_rvalid        = rd_beat_s & ~owner_r;
    assign p1_rvalid        = rd_beat_s &  owner_r;
    assign p0_rlast         = rd_last_s & ~owner_r;
    assign p1_rlast         = rd_last_s &  owner_r;
    assign p0_rdata         = rd_data;
    assign p1_rdata         = rd_data;
    assign cmd_en           = cmd_en_s;
    assign cmd              = cmd_r;
    assign addr             = addr_r;
    assign app_burst_number = burst_r;
    assign wr_data_en       = wr_fire_s;
    assign wr_data_end      = wr_fire_s;
    // Write data is zeroed outside the write path so idle outputs read 0.
    assign wr_data          = wr_path_s ? (owner_r ? p1_wdata : p0_wdata) : '0;
    assign wr_data_mask     = wr_path_s ? (owner_r ? p1_wmask : p0_wmask) : '0;
    assign err              = err_r;

endmodule

// File: tb/tb_ddr3_app_arbiter.sv
// Directed self-checking bench for ddr3_app_arbiter; inputs change on the
// falling edge and outputs are sampled 1 time unit later.
module tb_ddr3_app_arbiter;

    localparam int AW = 28;
    localparam int DW = 128;
    localparam int MW = 16;
    localparam int BW = 6;
    localparam logic [DW-1:0] D0 = 128'h0123456789abcdeffedcba9876543210;
    localparam logic [AW-1:0] A0 = 28'h1234560;
    localparam logic [AW-1:0] A1 = 28'h0abcde0;

    logic clk = 1'b0;
    logic rst;
    logic p0_req_valid, p0_req_ready, p0_wdata_valid, p0_wdata_ready, p0_rvalid, p0_rlast;
    logic p1_req_valid, p1_req_ready, p1_wdata_valid, p1_wdata_ready, p1_rvalid, p1_rlast;
    logic [2:0]    p0_req_cmd, p1_req_cmd, cmd;
    logic [AW-1:0] p0_req_addr, p1_req_addr, addr;
    logic [BW-1:0] p0_req_burst, p1_req_burst, app_burst_number;
    logic [DW-1:0] p0_wdata, p1_wdata, p0_rdata, p1_rdata, wr_data, rd_data;
    logic [MW-1:0] p0_wmask, p1_wmask, wr_data_mask;
    logic init_calib_complete, cmd_ready, wr_data_rdy, cmd_en;
    logic wr_data_en, wr_data_end, rd_data_valid, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ddr3_app_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_cmd(p0_req_cmd),
        .p0_req_addr(p0_req_addr), .p0_req_burst(p0_req_burst), .p0_wdata_valid(p0_wdata_valid),
        .p0_wdata_ready(p0_wdata_ready), .p0_wdata(p0_wdata), .p0_wmask(p0_wmask),
        .p0_rvalid(p0_rvalid), .p0_rlast(p0_rlast), .p0_rdata(p0_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_cmd(p1_req_cmd),
        .p1_req_addr(p1_req_addr), .p1_req_burst(p1_req_burst), .p1_wdata_valid(p1_wdata_valid),
        .p1_wdata_ready(p1_wdata_ready), .p1_wdata(p1_wdata), .p1_wmask(p1_wmask),
        .p1_rvalid(p1_rvalid), .p1_rlast(p1_rlast), .p1_rdata(p1_rdata),
        .init_calib_complete(init_calib_complete), .cmd_ready(cmd_ready), .wr_data_rdy(wr_data_rdy),
        .cmd_en(cmd_en), .cmd(cmd), .addr(addr), .app_burst_number(app_burst_number),
        .wr_data_en(wr_data_en), .wr_data_end(wr_data_end), .wr_data(wr_data),
        .wr_data_mask(wr_data_mask), .rd_data_valid(rd_data_valid), .rd_data(rd_data), .err(err)
    );

    task automatic drive_idle();
        p0_req_valid = 1'b0; p0_req_cmd = 3'd0; p0_req_addr = '0; p0_req_burst = '0;
        p0_wdata_valid = 1'b0; p0_wdata = '0; p0_wmask = '0;
        p1_req_valid = 1'b0; p1_req_cmd = 3'd0; p1_req_addr = '0; p1_req_burst = '0;
        p1_wdata_valid = 1'b0; p1_wdata = '0; p1_wmask = '0;
        init_calib_complete = 1'b1; cmd_ready = 1'b1; wr_data_rdy = 1'b1;
        rd_data_valid = 1'b0; rd_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        p0_wdata = '1; p0_wmask = '1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if ({cmd_en, wr_data_en, wr_data_end, err, p0_req_ready, p1_req_ready, p0_wdata_ready,
             p1_wdata_ready, p0_rvalid, p1_rvalid, p0_rlast, p1_rlast} !== 12'b0) begin
            errors++; $display("FAIL reset_strobes: some control output is nonzero after reset");
        end
        checks++;
        if (cmd !== 3'd0 || addr !== '0 || app_burst_number !== '0) begin
            errors++; $display("FAIL reset_cmd: cmd=%0d addr=%h burst=%0d expected all 0", cmd, addr, app_burst_number);
        end
        checks++;
        if (wr_data !== '0 || wr_data_mask !== '0) begin
            errors++; $display("FAIL reset_wdata: wr_data=%h mask=%h expected 0", wr_data, wr_data_mask);
        end
        drive_idle();
    endtask

    task automatic test_write_p0();
        int beats;
        int cmds;
        beats = 0; cmds = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            p0_req_valid = (cyc == 0); p0_req_cmd = 3'd0; p0_req_addr = '0; p0_req_burst = 6'd7;
            p0_wdata_valid = 1'b1; p0_wdata = D0 + 128'(beats); p0_wmask = 16'h00f0 ^ 16'(beats);
            #1;
            if (cyc == 0) begin
                checks++;
                if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL wr_accept: ready=%b expected 1", p0_req_ready); end
            end
            if (cyc == 1) begin
                checks++;
                if (cmd_en !== 1'b1) begin errors++; $display("FAIL wr_latency: cmd_en=%b expected 1", cmd_en); end
            end
            if (cmd_en === 1'b1) begin
                cmds++;
                checks++;
                if (cmd !== 3'd0 || wr_data_en !== 1'b1 || beats != 0) begin
                    errors++; $display("FAIL wr_cmd: cmd=%0d wr_data_en=%b beat=%0d expected 0/1/0", cmd, wr_data_en, beats);
                end
            end
            if (wr_data_en === 1'b1) begin
                checks++;
                if (wr_data !== D0 + 128'(beats) || wr_data_mask !== (16'h00f0 ^ 16'(beats)) ||
                    wr_data_end !== 1'b1 || p0_wdata_ready !== 1'b1) begin
                    errors++; $display("FAIL wr_beat: beat %0d data=%h expected %h", beats, wr_data, D0 + 128'(beats));
                end
                beats++;
            end
        end
        drive_idle();
        checks++;
        if (beats != 8 || cmds != 1) begin
            errors++; $display("FAIL wr_count: beats=%0d cmds=%0d expected 8/1", beats, cmds);
        end
    endtask

    task automatic test_read_p1();
        int beats;
        int p0v;
        int lasts;
        beats = 0; p0v = 0; lasts = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            p1_req_valid = (cyc == 0); p1_req_cmd = 3'd1; p1_req_addr = '0; p1_req_burst = 6'd7;
            rd_data_valid = (cyc >= 4 && cyc <= 7) || (cyc >= 9 && cyc <= 12);
            rd_data = ~D0 ^ 128'(cyc);
            #1;
            if (cyc == 0) begin
                checks++;
                if (p1_req_ready !== 1'b1 || p0_req_ready !== 1'b0) begin
                    errors++; $display("FAIL rd_accept: p1_ready=%b p0_ready=%b expected 1/0", p1_req_ready, p0_req_ready);
                end
            end
            if (cyc == 1) begin
                checks++;
                if (cmd_en !== 1'b1 || cmd !== 3'd1 || app_burst_number !== 6'd7 || wr_data_en !== 1'b0) begin
                    errors++; $display("FAIL rd_cmd: cmd_en=%b cmd=%0d burst=%0d expected 1/1/7", cmd_en, cmd, app_burst_number);
                end
            end
            if (cyc >= 2) begin
                checks++;
                if (p1_rvalid !== rd_data_valid) begin
                    errors++; $display("FAIL rd_valid: cyc %0d p1_rvalid=%b expected %b", cyc, p1_rvalid, rd_data_valid);
                end
            end
            if (p1_rvalid === 1'b1) begin
                checks++;
                if (p1_rdata !== (~D0 ^ 128'(cyc)) || p0_rdata !== (~D0 ^ 128'(cyc)) ||
                    p1_rlast !== (beats == 7)) begin
                    errors++; $display("FAIL rd_beat: beat %0d rlast=%b data=%h", beats, p1_rlast, p1_rdata);
                end
                beats++;
            end
            if (p0_rvalid === 1'b1) p0v++;
            if (p1_rlast === 1'b1) lasts++;
        end
        drive_idle();
        checks++;
        if (beats != 8 || p0v != 0 || lasts != 1 || err !== 1'b0) begin
            errors++; $display("FAIL rd_count: beats=%0d p0_rvalid=%0d rlast=%0d err=%b expected 8/0/1/0", beats, p0v, lasts, err);
        end
    endtask

    task automatic test_alternate();
        int ng;
        int r0;
        int r1;
        logic pend;
        ng = 0; r0 = 0; r1 = 0; pend = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            p0_req_valid = (ng < 6); p0_req_cmd = 3'd1; p0_req_addr = A0; p0_req_burst = '0;
            p1_req_valid = (ng < 6); p1_req_cmd = 3'd1; p1_req_addr = A1; p1_req_burst = '0;
            rd_data_valid = pend; pend = 1'b0;
            #1;
            if (p0_req_ready === 1'b1 || p1_req_ready === 1'b1) begin
                checks++;
                if ({p1_req_ready, p0_req_ready} !== ((ng % 2 == 1) ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL alt_grant: grant %0d ready={%b,%b} expected port %0d", ng, p1_req_ready, p0_req_ready, ng % 2);
                end
                ng++;
            end
            if (cmd_en === 1'b1) begin
                pend = 1'b1;
                checks++;
                if (addr !== (((ng - 1) % 2 == 1) ? A1 : A0)) begin
                    errors++; $display("FAIL alt_addr: addr=%h for grant %0d", addr, ng - 1);
                end
            end
            if (p0_rvalid === 1'b1) r0++;
            if (p1_rvalid === 1'b1) r1++;
        end
        drive_idle();
        checks++;
        if (ng != 6 || r0 != 3 || r1 != 3) begin
            errors++; $display("FAIL alt_count: grants=%0d p0_rvalid=%0d p1_rvalid=%0d expected 6/3/3", ng, r0, r1);
        end
    endtask

    task automatic test_wr_throttle();
        int beats;
        int cmds;
        int bad;
        beats = 0; cmds = 0; bad = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            p0_req_valid = (cyc == 0); p0_req_cmd = 3'd0; p0_req_addr = A0; p0_req_burst = 6'd3;
            p0_wdata_valid = 1'b1; p0_wdata = D0 ^ 128'(beats + 16); p0_wmask = 16'h0f0f;
            wr_data_rdy = (cyc % 2 == 0);
            #1;
            if (wr_data_rdy == 1'b0 && (wr_data_en !== 1'b0 || cmd_en !== 1'b0)) bad++;
            if (p0_wdata_ready !== wr_data_en) bad++;
            if (cmd_en === 1'b1) cmds++;
            if (wr_data_en === 1'b1) begin
                checks++;
                if (wr_data !== (D0 ^ 128'(beats + 16)) || wr_data_mask !== 16'h0f0f) begin
                    errors++; $display("FAIL thr_beat: beat %0d data=%h", beats, wr_data);
                end
                beats++;
            end
        end
        drive_idle();
        checks++;
        if (beats != 4 || cmds != 1 || bad != 0) begin
            errors++; $display("FAIL thr_count: beats=%0d cmds=%0d violations=%0d expected 4/1/0", beats, cmds, bad);
        end
    endtask

    task automatic test_err();
        @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clear: err=%b expected 0", err); end
        @(negedge clk);
        rd_data_valid = 1'b1;
        #1;
        checks++;
        if (p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
            errors++; $display("FAIL err_stray_rvalid: p0=%b p1=%b expected 0", p0_rvalid, p1_rvalid);
        end
        @(negedge clk);
        rd_data_valid = 1'b0;
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_stray: err=%b expected 1", err); end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: err=%b expected 1", err); end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        p1_req_valid = 1'b1; p1_req_cmd = 3'd5;
        #1;
        checks++;
        if (err !== 1'b0 || p1_req_ready !== 1'b1) begin
            errors++; $display("FAIL err_illegal_accept: err=%b ready=%b expected 0/1", err, p1_req_ready);
        end
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_cmd = 3'd5;
        #1;
        checks++;
        if (err !== 1'b1 || cmd_en !== 1'b0 || p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
            errors++; $display("FAIL err_illegal: err=%b cmd_en=%b ready={%b,%b} expected 1/0/{0,1}",
                               err, cmd_en, p1_req_ready, p0_req_ready);
        end
        @(negedge clk);
        drive_idle();
        #1;
        checks++;
        if (err !== 1'b1 || cmd_en !== 1'b0 || p0_rvalid !== 1'b0 || p1_rvalid !== 1'b0) begin
            errors++; $display("FAIL err_hold: err=%b cmd_en=%b expected 1/0", err, cmd_en);
        end
    endtask

    task automatic test_reset_mid();
        int beats;
        beats = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            p1_req_valid = (cyc == 0); p1_req_cmd = 3'd1; p1_req_addr = A1; p1_req_burst = 6'd7;
            rd_data_valid = (cyc >= 2);
            #1;
            if (p1_rvalid === 1'b1) beats++;
        end
        @(negedge clk);
        rst = 1'b1; rd_data_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (beats != 3 || {cmd_en, wr_data_en, err, p0_req_ready, p1_req_ready, p0_rvalid, p1_rvalid,
                           p0_rlast, p1_rlast} !== 9'b0 || cmd !== 3'd0 || addr !== '0 ||
            app_burst_number !== '0) begin
            errors++; $display("FAIL rst_mid: beats=%0d addr=%h burst=%0d err=%b expected 3 beats, all outputs 0",
                               beats, addr, app_burst_number, err);
        end
        @(negedge clk);
        p0_req_valid = 1'b1; p0_req_cmd = 3'd1;
        p1_req_valid = 1'b1; p1_req_cmd = 3'd1;
        #1;
        checks++;
        if (p0_req_ready !== 1'b1 || p1_req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_first_grant: ready={%b,%b} expected port 0", p1_req_ready, p0_req_ready);
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_write_p0();
        test_read_p1();
        test_alternate();
        test_wr_throttle();
        test_err();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
